// File: rtl/snoop_bus_if.sv
// Snoop-bus bundle between the per-core snoop ports and the shared arbiter.
// The master side is the core cluster; the slave side is the arbiter.
interface snoop_bus_if #(
  parameter int N_CORES = 2
);
  logic [N_CORES-1:0]    snp_own_sendM_valid;
  logic [N_CORES-1:0]    snp_own_sendS_valid;
  logic [6*N_CORES-1:0]  snp_own_sendM_atop;
  logic [32*N_CORES-1:0] snp_own_send_addr;
  logic [N_CORES-1:0]    snp_other_sendM_valid;
  logic [31:0]           snp_other_sendM_addr;
  logic [N_CORES-1:0]    snp_gnt;
  logic [N_CORES-1:0]    snp_bus_sc_gnt;
  logic [N_CORES-1:0]    snp_bus_exokay;

  modport master (
    output snp_own_sendM_valid, snp_own_sendS_valid, snp_own_sendM_atop, snp_own_send_addr,
    input  snp_other_sendM_valid, snp_other_sendM_addr, snp_gnt, snp_bus_sc_gnt, snp_bus_exokay
  );

  modport slave (
    input  snp_own_sendM_valid, snp_own_sendS_valid, snp_own_sendM_atop, snp_own_send_addr,
    output snp_other_sendM_valid, snp_other_sendM_addr, snp_gnt, snp_bus_sc_gnt, snp_bus_exokay
  );
endinterface

// File: rtl/snoop_bus_arbiter.sv
// Round-robin snoop-bus arbiter: serialises per-core store/LR/SC requests,
// broadcasts stores to the other cores and tracks LR/SC reservations.
module snoop_bus_arbiter #(
  parameter int          N_CORES = 2,
  parameter logic [5:0]  ATOP_LR = 6'b100001,
  parameter logic [5:0]  ATOP_SC = 6'b100010
) (
  input  logic       aclk,
  input  logic       areset,
  snoop_bus_if.slave bus
);

  localparam int IDX_W = $clog2(N_CORES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BCAST = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [31:0]        addr_q, addr_d;
  logic [5:0]         atop_q, atop_d;
  logic               is_m_q, is_m_d;
  logic               fwd_q, fwd_d;
  logic [N_CORES-1:0] res_vld_q, res_vld_d;
  logic [29:0]        res_addr_q [N_CORES];
  logic [29:0]        res_addr_d [N_CORES];
  logic [N_CORES-1:0] other_vld_q, other_vld_d;
  logic [31:0]        other_addr_q, other_addr_d;
  logic [N_CORES-1:0] gnt_q, gnt_d;
  logic [N_CORES-1:0] sc_gnt_q, sc_gnt_d;
  logic [N_CORES-1:0] exokay_q, exokay_d;

  logic [N_CORES-1:0] req_s;
  logic               found_s;
  logic [IDX_W-1:0]   pick_s;
  logic               pick_m_s;
  logic [5:0]         pick_atop_s;
  logic [31:0]        pick_addr_s;
  logic               pick_fwd_s;

  // Round-robin pick starting one past the previous winner, plus the picked core's fields.
  always_comb begin
    req_s   = bus.snp_own_sendM_valid | bus.snp_own_sendS_valid;
    found_s = 1'b0;
    pick_s  = '0;
    for (int k = 1; k <= N_CORES; k++) begin
      if (!found_s && req_s[(int'(last_q) + k) % N_CORES]) begin
        found_s = 1'b1;
        pick_s  = IDX_W'((int'(last_q) + k) % N_CORES);
      end else begin
        found_s = found_s;
      end
    end
    pick_m_s    = bus.snp_own_sendM_valid[pick_s];
    pick_atop_s = bus.snp_own_sendM_atop[6*int'(pick_s) +: 6];
    pick_addr_s = bus.snp_own_send_addr[32*int'(pick_s) +: 32];
    // The table cannot change before BCAST ends, so the SC check can be done at selection time.
    if (!pick_m_s) begin
      pick_fwd_s = 1'b0;
    end else if (pick_atop_s != ATOP_SC) begin
      pick_fwd_s = 1'b1;
    end else begin
      pick_fwd_s = res_vld_q[pick_s] && (res_addr_q[pick_s] == pick_addr_s[31:2]);
    end
  end

  // Transaction FSM: next state, latched request, reservation table and output pulses.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    win_d        = win_q;
    addr_d       = addr_q;
    atop_d       = atop_q;
    is_m_d       = is_m_q;
    fwd_d        = fwd_q;
    res_vld_d    = res_vld_q;
    res_addr_d   = res_addr_q;
    other_vld_d  = '0;
    other_addr_d = 32'h0000_0000;
    gnt_d        = '0;
    sc_gnt_d     = '0;
    exokay_d     = '0;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          state_d = BCAST;
          win_d   = pick_s;
          last_d  = pick_s;
          addr_d  = pick_addr_s;
          atop_d  = pick_m_s ? pick_atop_s : ATOP_LR;
          is_m_d  = pick_m_s;
          fwd_d   = pick_fwd_s;
          if (pick_fwd_s) begin
            other_vld_d  = ~(N_CORES'(1) << pick_s);
            other_addr_d = pick_addr_s;
          end else begin
            other_vld_d  = '0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BCAST: begin
        state_d = RESP;
        for (int i = 0; i < N_CORES; i++) begin
          if (IDX_W'(i) == win_q) begin
            if (!is_m_q) begin
              res_vld_d[i]  = 1'b1;
              res_addr_d[i] = addr_q[31:2];
            end else if (atop_q == ATOP_SC) begin
              res_vld_d[i]  = 1'b0;
            end else begin
              res_vld_d[i]  = res_vld_q[i];
            end
          end else if (fwd_q && (res_addr_q[i] == addr_q[31:2])) begin
            res_vld_d[i] = 1'b0;
          end else begin
            res_vld_d[i] = res_vld_q[i];
          end
        end
        gnt_d[win_q] = 1'b1;
        if (is_m_q && (atop_q == ATOP_SC)) begin
          sc_gnt_d[win_q] = 1'b1;
          exokay_d[win_q] = fwd_q;
        end else begin
          sc_gnt_d[win_q] = 1'b0;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= IDLE;
      last_q       <= IDX_W'(N_CORES - 1);
      win_q        <= '0;
      addr_q       <= 32'h0000_0000;
      atop_q       <= 6'b000000;
      is_m_q       <= 1'b0;
      fwd_q        <= 1'b0;
      res_vld_q    <= '0;
      for (int i = 0; i < N_CORES; i++) begin
        res_addr_q[i] <= 30'h0000_0000;
      end
      other_vld_q  <= '0;
      other_addr_q <= 32'h0000_0000;
      gnt_q        <= '0;
      sc_gnt_q     <= '0;
      exokay_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      win_q        <= win_d;
      addr_q       <= addr_d;
      atop_q       <= atop_d;
      is_m_q       <= is_m_d;
      fwd_q        <= fwd_d;
      res_vld_q    <= res_vld_d;
      res_addr_q   <= res_addr_d;
      other_vld_q  <= other_vld_d;
      other_addr_q <= other_addr_d;
      gnt_q        <= gnt_d;
      sc_gnt_q     <= sc_gnt_d;
      exokay_q     <= exokay_d;
    end
  end

  assign bus.snp_other_sendM_valid = other_vld_q;
  assign bus.snp_other_sendM_addr  = other_addr_q;
  assign bus.snp_gnt               = gnt_q;
  assign bus.snp_bus_sc_gnt        = sc_gnt_q;
  assign bus.snp_bus_exokay        = exokay_q;

endmodule
